// File: rtl/decoder_seq_pkg.sv
// Shared types and defaults for the decoder / auto-scan sequencer.
package decoder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int unsigned DIV_DEFAULT        = 4;
    localparam int unsigned WRAP_LIMIT_DEFAULT = 0;

    localparam int unsigned IDX_W      = 3;
    localparam int unsigned OUT_W      = 8;
    localparam int unsigned PRESC_W    = 8;
    localparam int unsigned WRAP_CNT_W = 16;

endpackage

// File: rtl/decoder_seq_onehot_dec3to8.sv
// Combinational 3-to-8 one-hot decoder shared by the direct and scan paths.
module onehot_dec3to8
    import decoder_seq_pkg::*;
(
    input  logic [IDX_W-1:0] sel,
    output logic [OUT_W-1:0] onehot_c
);

    // Exactly one bit set for every select value.
    always_comb begin
        onehot_c      = '0;
        onehot_c[sel] = 1'b1;
    end

endmodule

// File: rtl/decoder_seq.sv
// Direct 3-to-8 decoder with an auto-scan mode and optional wrap-limited stop.
module decoder_seq
    import decoder_seq_pkg::*;
#(
    parameter int unsigned DIV        = DIV_DEFAULT,
    parameter int unsigned WRAP_LIMIT = WRAP_LIMIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e,
    input  logic             mode,
    input  logic [IDX_W-1:0] in,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             wrap,
    output logic             busy
);

    state_e                state_q,     state_d;
    logic [OUT_W-1:0]      out_q,       out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  wrap_q,      wrap_d;
    logic                  busy_q,      busy_d;
    logic [IDX_W-1:0]      index_q,     index_d;
    logic [PRESC_W-1:0]    presc_q,     presc_d;
    logic [WRAP_CNT_W-1:0] wrap_cnt_q,  wrap_cnt_d;

    logic                  step_c;
    logic [IDX_W-1:0]      idx_scan_c;
    logic [IDX_W-1:0]      dec_sel_c;
    logic [OUT_W-1:0]      dec_out_c;

    // Scan step detection and selection of what the shared decoder sees.
    always_comb begin
        step_c     = (presc_q == PRESC_W'(DIV - 1));
        idx_scan_c = step_c ? (index_q + IDX_W'(1)) : index_q;
        dec_sel_c  = '0;
        if (state_q == ST_DIRECT && !mode) begin
            dec_sel_c = in;
        end else if (state_q == ST_SCAN && mode) begin
            dec_sel_c = idx_scan_c;
        end
    end

    onehot_dec3to8 u_dec (
        .sel      (dec_sel_c),
        .onehot_c (dec_out_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        wrap_d      = 1'b0;
        index_d     = index_q;
        presc_d     = presc_q;
        wrap_cnt_d  = wrap_cnt_q;

        if (!e) begin
            state_d = ST_IDLE;
            out_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    out_d = '0;
                    if (mode) begin
                        state_d    = ST_SCAN;
                        index_d    = '0;
                        presc_d    = '0;
                        wrap_cnt_d = '0;
                        out_d      = dec_out_c;
                    end else begin
                        state_d = ST_DIRECT;
                    end
                end
                ST_DIRECT: begin
                    if (mode) begin
                        state_d    = ST_SCAN;
                        index_d    = '0;
                        presc_d    = '0;
                        wrap_cnt_d = '0;
                        out_d      = dec_out_c;
                    end else if (in_valid) begin
                        out_d       = dec_out_c;
                        out_valid_d = 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (!mode) begin
                        state_d = ST_DIRECT;
                        out_d   = '0;
                    end else if (step_c) begin
                        presc_d = '0;
                        index_d = idx_scan_c;
                        out_d   = dec_out_c;
                        if (index_q == IDX_W'(7)) begin
                            wrap_d = 1'b1;
                            if (WRAP_LIMIT != 0 &&
                                (32'(wrap_cnt_q) + 32'd1) == WRAP_LIMIT) begin
                                state_d = ST_DONE;
                                out_d   = '0;
                            end else if (WRAP_LIMIT != 0) begin
                                wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
                            end
                        end
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                ST_DONE: begin
                    out_d = '0;
                    if (!mode) begin
                        state_d = ST_DIRECT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    out_d   = '0;
                end
            endcase
        end

        busy_d = (state_d == ST_SCAN);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            busy_q      <= 1'b0;
            index_q     <= '0;
            presc_q     <= '0;
            wrap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            wrap_q      <= wrap_d;
            busy_q      <= busy_d;
            index_q     <= index_d;
            presc_q     <= presc_d;
            wrap_cnt_q  <= wrap_cnt_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign wrap      = wrap_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: one DUT with DIV=4 unlimited, one with DIV=1 WRAP_LIMIT=2.
module tb_decoder_seq;

    logic       clk;
    logic       rst;
    logic       e;
    logic       mode;
    logic [2:0] in;
    logic       in_valid;

    logic [7:0] out_a, out_b;
    logic       ov_a, ov_b;
    logic       wrap_a, wrap_b;
    logic       busy_a, busy_b;

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    decoder_seq #(.DIV(4), .WRAP_LIMIT(0)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .e         (e),
        .mode      (mode),
        .in        (in),
        .in_valid  (in_valid),
        .out       (out_a),
        .out_valid (ov_a),
        .wrap      (wrap_a),
        .busy      (busy_a)
    );

    decoder_seq #(.DIV(1), .WRAP_LIMIT(2)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .e         (e),
        .mode      (mode),
        .in        (in),
        .in_valid  (in_valid),
        .out       (out_b),
        .out_valid (ov_b),
        .wrap      (wrap_b),
        .busy      (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       e;
        logic       mode;
        logic [2:0] in;
        logic       iv;
        logic [7:0] exp_out;
        logic       exp_ov;
        logic       exp_wrap;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic ei, input logic mi, input logic [2:0] ii,
                                input logic vi, input logic [7:0] eo, input logic ev,
                                input logic ew, input logic eb);
        vec_t v;
        v.e = ei; v.mode = mi; v.in = ii; v.iv = vi;
        v.exp_out = eo; v.exp_ov = ev; v.exp_wrap = ew; v.exp_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Output must always be zero or exactly one-hot.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            checks++;
            if (((out_a & (out_a - 8'd1)) != 8'd0) || ((out_b & (out_b - 8'd1)) != 8'd0)) begin
                failures++;
                $display("FAIL onehot: out_a=0x%0h out_b=0x%0h", out_a, out_b);
            end
        end
    end

    initial begin
        logic [7:0] ea, eb;
        logic       wa, wb, bb;

        rst = 1'b1; e = 1'b0; mode = 1'b0; in = 3'd0; in_valid = 1'b0;

        vecs[0]  = mk(1, 0, 3'd0, 0, 8'h00, 0, 0, 0);
        vecs[1]  = mk(1, 0, 3'd5, 1, 8'h20, 1, 0, 0);
        vecs[2]  = mk(1, 0, 3'd5, 0, 8'h20, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            vecs[3 + i] = mk(1, 0, 3'(i), 1, 8'(1 << i), 1, 0, 0);
        vecs[11] = mk(1, 0, 3'd3, 0, 8'h80, 0, 0, 0);
        vecs[12] = mk(1, 1, 3'd3, 1, 8'h01, 0, 0, 1);
        vecs[13] = mk(1, 1, 3'd6, 1, 8'h01, 0, 0, 1);
        vecs[14] = mk(1, 0, 3'd6, 1, 8'h00, 0, 0, 0);
        vecs[15] = mk(1, 0, 3'd6, 1, 8'h40, 1, 0, 0);
        vecs[16] = mk(0, 0, 3'd6, 1, 8'h00, 0, 0, 0);
        vecs[17] = mk(0, 1, 3'd6, 1, 8'h00, 0, 0, 0);

        step();
        step();
        chk("reset_out", 32'(out_a), 32'h00);
        chk("reset_ov", 32'(ov_a), 32'd0);
        chk("reset_wrap", 32'(wrap_a), 32'd0);
        chk("reset_busy", 32'(busy_a), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Direct-mode table, including mode changes and enable drop.
        for (int i = 0; i < 18; i++) begin
            e = vecs[i].e; mode = vecs[i].mode; in = vecs[i].in; in_valid = vecs[i].iv;
            step();
            chk($sformatf("vec%0d_out", i), 32'(out_a), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d_ov", i), 32'(ov_a), 32'(vecs[i].exp_ov));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap_a), 32'(vecs[i].exp_wrap));
            chk($sformatf("vec%0d_busy", i), 32'(busy_a), 32'(vecs[i].exp_busy));
        end

        // Scan: DIV=4 unlimited on dut_a, DIV=1 with two-wrap stop on dut_b.
        in_valid = 1'b0; e = 1'b0; mode = 1'b0;
        do_reset();
        e = 1'b1; mode = 1'b1;
        step();
        chk("scan_entry_a", 32'(out_a), 32'h01);
        chk("scan_entry_b", 32'(out_b), 32'h01);
        chk("scan_entry_busy", 32'(busy_a), 32'd1);
        for (int c = 1; c <= 33; c++) begin
            step();
            ea = (c < 32) ? 8'(1 << (c / 4)) : 8'h01;
            wa = (c == 32);
            chk($sformatf("scan_a_out_c%0d", c), 32'(out_a), 32'(ea));
            chk($sformatf("scan_a_wrap_c%0d", c), 32'(wrap_a), 32'(wa));
            chk($sformatf("scan_a_busy_c%0d", c), 32'(busy_a), 32'd1);
            if (c <= 20) begin
                eb = (c < 16) ? 8'(1 << (c % 8)) : 8'h00;
                wb = (c == 8) || (c == 16);
                bb = (c < 16);
                chk($sformatf("scan_b_out_c%0d", c), 32'(out_b), 32'(eb));
                chk($sformatf("scan_b_wrap_c%0d", c), 32'(wrap_b), 32'(wb));
                chk($sformatf("scan_b_busy_c%0d", c), 32'(busy_b), 32'(bb));
            end
        end

        // Leaving SCAN / DONE for DIRECT clears out, then a decode lands.
        mode = 1'b0;
        step();
        chk("done_to_direct_b_out", 32'(out_b), 32'h00);
        chk("done_to_direct_b_busy", 32'(busy_b), 32'd0);
        chk("scan_to_direct_a_out", 32'(out_a), 32'h00);
        in = 3'd7; in_valid = 1'b1;
        step();
        chk("after_done_b_out", 32'(out_b), 32'h80);
        chk("after_done_b_ov", 32'(ov_b), 32'd1);
        in_valid = 1'b0;

        // Asynchronous reset while scanning at 8'h10.
        do_reset();
        e = 1'b1; mode = 1'b1;
        step();
        repeat (16) step();
        chk("pre_rst_out", 32'(out_a), 32'h10);
        rst = 1'b1;
        #1;
        chk("async_rst_out", 32'(out_a), 32'h00);
        chk("async_rst_busy", 32'(busy_a), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_scan_out", 32'(out_a), 32'h01);
        chk("post_rst_scan_busy", 32'(busy_a), 32'd1);

        // Enable dropped mid-scan, then direct decode of 3'd2.
        e = 1'b0; mode = 1'b0; in = 3'd2; in_valid = 1'b1;
        step();
        chk("e_low_out1", 32'(out_a), 32'h00);
        step();
        chk("e_low_out2", 32'(out_a), 32'h00);
        chk("e_low_ov", 32'(ov_a), 32'd0);
        e = 1'b1;
        step();
        chk("e_high_idle_out", 32'(out_a), 32'h00);
        chk("e_high_idle_ov", 32'(ov_a), 32'd0);
        step();
        chk("e_high_dec_out", 32'(out_a), 32'h04);
        chk("e_high_dec_ov", 32'(ov_a), 32'd1);
        in_valid = 1'b0;
        step();
        chk("e_high_hold_out", 32'(out_a), 32'h04);
        chk("e_high_hold_ov", 32'(ov_a), 32'd0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
